fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_if.sv | 31 +++
 rtl/fetch_queue.sv | 103 ++++++++++
 tb/tb_fetch_queue.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: producer-side instruction inputs, decode-side head
// outputs and status. Clock, reset and clock enable stay as plain ports.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          bubble_in;
  logic [31:0]   pc_in;
  logic [7:0]    exc_in;
  logic [31:0]   instr_in;
  logic          stall;
  logic          bubble_out;
  logic [31:0]   pc_out;
  logic [31:0]   instr_out;
  logic [7:0]    exc_out;
  logic          fetch_stall;
  logic [CW-1:0] count;
  logic          overflow_err;

  modport master (
    output flush, bubble_in, pc_in, exc_in, instr_in, stall,
    input  bubble_out, pc_out, instr_out, exc_out, fetch_stall, count, overflow_err
  );

  modport slave (
    input  flush, bubble_in, pc_in, exc_in, instr_in, stall,
    output bubble_out, pc_out, instr_out, exc_out, fetch_stall, count, overflow_err
  );
endinterface

// File: rtl/fetch_queue.sv
// Fetch queue: circular FIFO between the fetch pipeline and decode.
// Show-ahead head outputs, no enqueue->output bypass, sticky overflow flag,
// and early backpressure that leaves room for two in-flight memory fetches.
// DEPTH must be a power of two and at least 4.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_en,
  fetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Entry storage; contents are only meaningful below count, so no reset.
  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic [7:0]  exc_mem   [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          overflow_err;

  logic enq;
  logic deq;
  logic full;
  logic enq_accepted;
  logic enq_dropped;

  // Handshake decode: a full queue still accepts a write when the head leaves.
  always_comb begin
    enq          = clk_en & ~bus.flush & ~bus.bubble_in;
    deq          = clk_en & ~bus.flush & ~bus.stall & (count != {CW{1'b0}});
    full         = (count == CW'(DEPTH));
    enq_accepted = enq & (~full | deq);
    enq_dropped  = enq & full & ~deq;
  end

  // Write accepted entries; an excepting fetch carries no instruction word.
  always_ff @(posedge clk) begin
    if (enq_accepted) begin
      pc_mem[wr_ptr]    <= bus.pc_in;
      exc_mem[wr_ptr]   <= bus.exc_in;
      instr_mem[wr_ptr] <= (bus.exc_in != 8'h00) ? 32'h0000_0000 : bus.instr_in;
    end
  end

  // Pointer, occupancy and sticky-error state; flush outranks enq/deq.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= {AW{1'b0}};
      wr_ptr       <= {AW{1'b0}};
      count        <= {CW{1'b0}};
      overflow_err <= 1'b0;
    end else if (clk_en) begin
      if (bus.flush) begin
        rd_ptr <= {AW{1'b0}};
        wr_ptr <= {AW{1'b0}};
        count  <= {CW{1'b0}};
      end else begin
        if (enq_accepted) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (deq) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        case ({enq_accepted, deq})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
        if (enq_dropped) begin
          overflow_err <= 1'b1;
        end
      end
    end
  end

  // Show-ahead head view; forced to zero while the queue is empty.
  always_comb begin
    bus.bubble_out   = 1'b1;
    bus.pc_out       = 32'h0000_0000;
    bus.instr_out    = 32'h0000_0000;
    bus.exc_out      = 8'h00;
    if (count != {CW{1'b0}}) begin
      bus.bubble_out = 1'b0;
      bus.pc_out     = pc_mem[rd_ptr];
      bus.instr_out  = instr_mem[rd_ptr];
      bus.exc_out    = exc_mem[rd_ptr];
    end else begin
      bus.bubble_out = 1'b1;
    end
  end

  // Status outputs; backpressure covers two fetches already in flight.
  always_comb begin
    bus.count        = count;
    bus.overflow_err = overflow_err;
    bus.fetch_stall  = (count >= CW'(DEPTH - 2));
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (DEPTH=4). The stimulus pushes the
// hand-computed entry every accepted enqueue; a monitor pops and compares
// whenever the DUT presents a head that will be consumed on the next edge.
module tb_fetch_queue;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [7:0]  exc;
  } ent_t;

  logic clk;
  logic rst_n;
  logic clk_en;
  int   n_tests;
  int   n_fail;
  ent_t exp_q[$];

  fetch_queue_if #(.DEPTH(4)) bus ();

  fetch_queue #(.DEPTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.bubble_in = 1'b1;
    bus.pc_in     = 32'h0;
    bus.instr_in  = 32'h0;
    bus.exc_in    = 8'h00;
  endtask

  // Drive one fetch for a cycle; push the expected entry when it is accepted.
  task automatic enq(input logic [31:0] pc, input logic [31:0] ins, input logic [7:0] exc,
                     input logic [31:0] exp_ins, input bit accepted);
    ent_t e;
    bus.bubble_in = 1'b0;
    bus.pc_in     = pc;
    bus.instr_in  = ins;
    bus.exc_in    = exc;
    if (accepted) begin
      e.pc = pc;
      e.instr = exp_ins;
      e.exc = exc;
      exp_q.push_back(e);
    end
    tick();
  endtask

  // Scoreboard monitor: a visible head with a dequeue due at the next edge.
  always @(negedge clk) begin
    if (rst_n && clk_en && !bus.flush && !bus.stall && !bus.bubble_out) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc 0x%08h expected no entry", bus.pc_out);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("sb_pc", bus.pc_out, e.pc);
        chk("sb_instr", bus.instr_out, e.instr);
        chk("sb_exc", 32'(bus.exc_out), 32'(e.exc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    clk_en  = 1'b1;
    bus.flush = 1'b0;
    bus.stall = 1'b1;
    idle();
    #3;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_bubble", 32'(bus.bubble_out), 32'd1);
    chk("rst_fstall", 32'(bus.fetch_stall), 32'd0);
    chk("rst_ovf", 32'(bus.overflow_err), 32'd0);
    #4 rst_n = 1'b1;
    tick();

    // Three fetches held by stall, then drained in order.
    bus.stall = 1'b1;
    bus.bubble_in = 1'b0;
    bus.pc_in = 32'h400;
    #1 chk("no_bypass", 32'(bus.bubble_out), 32'd1);
    enq(32'h400, 32'h1111_0000, 8'h00, 32'h1111_0000, 1'b1);
    enq(32'h404, 32'h1111_0004, 8'h00, 32'h1111_0004, 1'b1);
    enq(32'h408, 32'h1111_0008, 8'h00, 32'h1111_0008, 1'b1);
    idle();
    chk("r37_count", 32'(bus.count), 32'd3);
    chk("r37_fstall", 32'(bus.fetch_stall), 32'd1);
    chk("r37_head", bus.pc_out, 32'h400);
    bus.stall = 1'b0;
    tick();
    chk("r37_step1", bus.pc_out, 32'h404);
    tick();
    chk("r37_step2", bus.pc_out, 32'h408);
    tick();
    chk("r37_empty", 32'(bus.bubble_out), 32'd1);

    // Overflow: fifth enqueue into a full, stalled queue is dropped.
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) enq(32'h400 + 32'(4 * i), 32'hA000_0000 + 32'(i), 8'h00, 32'hA000_0000 + 32'(i), 1'b1);
    enq(32'h410, 32'hA000_0010, 8'h00, 32'h0, 1'b0);
    idle();
    chk("r38_count", 32'(bus.count), 32'd4);
    chk("r38_ovf", 32'(bus.overflow_err), 32'd1);
    chk("r38_head", bus.pc_out, 32'h400);
    bus.stall = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("r38_drained", 32'(bus.count), 32'd0);

    // Reset clears the sticky flag.
    #2 rst_n = 1'b0;
    #1 chk("rst2_ovf", 32'(bus.overflow_err), 32'd0);
    #3 rst_n = 1'b1;
    tick();

    // Full queue streaming through pointer wrap: enq+deq every cycle.
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) enq(32'h500 + 32'(4 * i), 32'hB000_0000 + 32'(i), 8'h00, 32'hB000_0000 + 32'(i), 1'b1);
    bus.stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      enq(32'h510 + 32'(4 * i), 32'hC000_0000 + 32'(i), 8'h00, 32'hC000_0000 + 32'(i), 1'b1);
      chk("r39_count", 32'(bus.count), 32'd4);
      chk("r39_head", bus.pc_out, 32'h504 + 32'(4 * i));
    end
    idle();
    chk("r39_ovf", 32'(bus.overflow_err), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("r39_drained", 32'(bus.bubble_out), 32'd1);

    // Exception entry stores a zero instruction word.
    bus.stall = 1'b1;
    enq(32'h600, 32'hDEAD_BEEF, 8'h84, 32'h0, 1'b1);
    idle();
    chk("r41_exc", 32'(bus.exc_out), 32'h84);
    chk("r41_instr", bus.instr_out, 32'h0);
    enq(32'h604, 32'h2222_0004, 8'h00, 32'h2222_0004, 1'b1);
    enq(32'h608, 32'h2222_0008, 8'h00, 32'h2222_0008, 1'b1);

    // Flush with enq and deq in the same cycle at count 3.
    bus.stall = 1'b0;
    bus.flush = 1'b1;
    bus.bubble_in = 1'b0;
    bus.pc_in = 32'h700;
    tick();
    exp_q.delete();
    bus.flush = 1'b0;
    idle();
    chk("r40_count", 32'(bus.count), 32'd0);
    chk("r40_bubble", 32'(bus.bubble_out), 32'd1);
    chk("r40_pc", bus.pc_out, 32'h0);

    // clk_en low ignores flush and input; async reset between edges.
    bus.stall = 1'b1;
    enq(32'h800, 32'h3333_0000, 8'h00, 32'h3333_0000, 1'b1);
    enq(32'h804, 32'h3333_0004, 8'h00, 32'h3333_0004, 1'b1);
    clk_en = 1'b0;
    bus.flush = 1'b1;
    bus.stall = 1'b0;
    bus.bubble_in = 1'b0;
    bus.pc_in = 32'h900;
    tick();
    tick();
    chk("r42_hold_count", 32'(bus.count), 32'd2);
    chk("r42_hold_head", bus.pc_out, 32'h800);
    #2 rst_n = 1'b0;
    #1;
    chk("r42_async_count", 32'(bus.count), 32'd0);
    chk("r42_async_bubble", 32'(bus.bubble_out), 32'd1);
    exp_q.delete();
    clk_en = 1'b1;
    bus.flush = 1'b0;
    bus.stall = 1'b1;
    idle();
    #2 rst_n = 1'b1;
    tick();

    // First entry after reset reaches the head.
    enq(32'hA00, 32'h4444_0000, 8'h00, 32'h4444_0000, 1'b1);
    idle();
    chk("r35_head", bus.pc_out, 32'hA00);
    bus.stall = 1'b0;
    tick();
    chk("r35_empty", 32'(bus.bubble_out), 32'd1);
    chk("sb_left", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
